chart_read_arbiter: RTL and testbench

CHART_READ_ARBITER -- requirements
Module: chart_read_arbiter

---
 rtl/chart_read_arbiter_if.sv | 25 ++
 rtl/chart_read_arbiter.sv | 142 ++++++++++++++
 tb/tb_chart_read_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/chart_read_arbiter_if.sv
// Request/grant/response bundle between chart requesters, the arbiter and the chart store.
// The master side drives requests and store read data; the slave side is the arbiter.
interface chart_read_arbiter_if #(
    parameter int N_REQ   = 3,
    parameter int CHART_W = 16
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*8-1:0] req_id;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   rsp_valid;
    logic [CHART_W-1:0] rsp_chart;
    logic [7:0]         rom_chart_id;
    logic [CHART_W-1:0] rom_chart_data;
    logic               busy;

    modport master (
        output req, req_id, rom_chart_data,
        input  gnt, rsp_valid, rsp_chart, rom_chart_id, busy
    );

    modport slave (
        input  req, req_id, rom_chart_data,
        output gnt, rsp_valid, rsp_chart, rom_chart_id, busy
    );
endinterface

// File: rtl/chart_read_arbiter.sv
// Chart read arbiter: serialises page requests onto the shared chart store, one read at a time.
// Define CHART_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module chart_read_arbiter #(
    parameter int N_REQ    = 3,
    parameter int READ_LAT = 1,
    parameter int CHART_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    chart_read_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [N_REQ-1:0]   gnt_r;
    logic [N_REQ-1:0]   rsp_valid_r;
    logic [CHART_W-1:0] rsp_chart_r;
    logic [7:0]         rom_chart_id_r;
    logic               busy_r;

    logic               win_vld_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic [7:0]         win_id_s;
    logic [N_REQ-1:0]   win_oh_s;

`ifdef CHART_ARB_RR_EN
    logic [IDX_W-1:0]   ptr_r;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] ptr, input int step);
        int sum;
        sum = int'(ptr) + step + 1;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end else begin
            sum = sum;
        end
        return IDX_W'(sum);
    endfunction

    // Round-robin winner search, starting one past the last winner.
    always_comb begin
        win_vld_s = 1'b0;
        win_idx_s = {IDX_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_vld_s && bus.req[rr_idx(ptr_r, k)]) begin
                win_vld_s = 1'b1;
                win_idx_s = rr_idx(ptr_r, k);
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    // Last-winner pointer, advanced on every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= IDX_W'(N_REQ - 1);
        end else if (state_r == IDLE && win_vld_s) begin
            ptr_r <= win_idx_s;
        end
    end
`else
    // Fixed-priority winner search, lowest index first.
    always_comb begin
        win_vld_s = 1'b0;
        win_idx_s = {IDX_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_vld_s && bus.req[k]) begin
                win_vld_s = 1'b1;
                win_idx_s = IDX_W'(k);
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end
`endif

    assign win_id_s = bus.req_id[{win_idx_s, 3'b000} +: 8];
    assign win_oh_s = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;

    // Transaction FSM: grant in IDLE, count down the store latency, deliver, then one bubble cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            gnt_r          <= {N_REQ{1'b0}};
            rsp_valid_r    <= {N_REQ{1'b0}};
            rsp_chart_r    <= {CHART_W{1'b0}};
            rom_chart_id_r <= 8'd0;
            busy_r         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_vld_s) begin
                        gnt_r          <= win_oh_s;
                        rom_chart_id_r <= win_id_s;
                        cnt_r          <= CNT_W'(READ_LAT);
                        busy_r         <= 1'b1;
                        state_r        <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        rsp_chart_r <= bus.rom_chart_data;
                        rsp_valid_r <= gnt_r;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                // Requests are deliberately ignored here so a requester can drop req after rsp_valid.
                DONE: begin
                    rsp_valid_r <= {N_REQ{1'b0}};
                    gnt_r       <= {N_REQ{1'b0}};
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    rsp_valid_r <= {N_REQ{1'b0}};
                    gnt_r       <= {N_REQ{1'b0}};
                    busy_r      <= 1'b0;
                    cnt_r       <= {CNT_W{1'b0}};
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt          = gnt_r;
    assign bus.rsp_valid    = rsp_valid_r;
    assign bus.rsp_chart    = rsp_chart_r;
    assign bus.rom_chart_id = rom_chart_id_r;
    assign bus.busy         = busy_r;
endmodule

// File: tb/tb_chart_read_arbiter.sv
// Bench for chart_read_arbiter: transaction-level model checked every cycle, directed cases, random traffic.
module tb_chart_read_arbiter;
    localparam int N   = 3;
    localparam int LAT = 1;
    localparam int CW  = 16;

    logic clk = 1'b0;
    logic rst;
    bit   chk_en = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    chart_read_arbiter_if #(.N_REQ(N), .CHART_W(CW)) bus ();

    chart_read_arbiter #(.N_REQ(N), .READ_LAT(LAT), .CHART_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Chart store: each entry carries its own id in the top byte, read through a LAT-deep pipe.
    logic [CW-1:0] mem  [256];
    logic [CW-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mem[bus.rom_chart_id];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.rom_chart_data = pipe[LAT-1];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int lw);
`ifdef CHART_ARB_RR_EN
        for (int k = 1; k <= N; k++) if (r[(lw + k) % N]) return (lw + k) % N;
`else
        for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
        return 0;
    endfunction

    // Transaction model: a grant at edge G delivers at edge G+1+LAT and frees the bus at G+2+LAT.
    int            ecnt = 0;
    int            g_e  = 0;
    bit            in_txn = 1'b0;
    bit            rv_m = 1'b0;
    int            win_m = 0;
    int            last_win = N - 1;
    logic [7:0]    id_m = 8'd0;
    logic [7:0]    exp_rom_id = 8'd0;
    logic [CW-1:0] exp_chart = '0;

    always @(posedge clk) begin
        ecnt <= ecnt + 1;
        rv_m <= 1'b0;
        if (rst) begin
            in_txn     <= 1'b0;
            exp_chart  <= '0;
            exp_rom_id <= 8'd0;
            last_win   <= N - 1;
        end else if (in_txn) begin
            if (ecnt == g_e + 1 + LAT) begin
                exp_chart <= mem[id_m];
                rv_m      <= 1'b1;
            end
            if (ecnt == g_e + 2 + LAT) in_txn <= 1'b0;
        end else if (bus.req != '0) begin
            in_txn     <= 1'b1;
            g_e        <= ecnt;
            win_m      <= pick(bus.req, last_win);
            last_win   <= pick(bus.req, last_win);
            id_m       <= bus.req_id[8*pick(bus.req, last_win) +: 8];
            exp_rom_id <= bus.req_id[8*pick(bus.req, last_win) +: 8];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt",       32'(bus.gnt),       in_txn ? (32'd1 << win_m) : 32'd0);
            check("rsp_valid", 32'(bus.rsp_valid), rv_m ? (32'd1 << win_m) : 32'd0);
            check("busy",      32'(bus.busy),      32'(in_txn));
            check("rom_id",    32'(bus.rom_chart_id), 32'(exp_rom_id));
            check("rsp_chart", 32'(bus.rsp_chart), 32'(exp_chart));
        end
    end

    task automatic wait_rv(input int idx, input string nm);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.rsp_valid[idx] && c < 20);
        check({nm, "_rv"}, 32'(bus.rsp_valid[idx]), 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (bus.busy && c < 20);
        check({nm, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    int order [4];
    int exp_ord [4];
    int ng;
    logic [N-1:0] pg;

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.req_id = '0;
        for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'($urandom)};
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rom_id", 32'(bus.rom_chart_id), 32'd0);
        check("rst_chart", 32'(bus.rsp_chart), 32'd0);
        rst = 1'b0;

        // Single request, id 3.
        bus.req_id[7:0] = 8'd3;
        bus.req = 3'b001;
        @(negedge clk);
        check("t1_rom_id", 32'(bus.rom_chart_id), 32'd3);
        check("t1_gnt", 32'(bus.gnt), 32'b001);
        @(negedge clk);
        check("t1_early_rv", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("t1_rv", 32'(bus.rsp_valid), 32'b001);
        check("t1_chart", 32'(bus.rsp_chart), 32'(mem[3]));
        check("t1_chart_tag", 32'(bus.rsp_chart[15:8]), 32'd3);
        bus.req = 3'b000;
        @(negedge clk);
        check("t1_busy_after", 32'(bus.busy), 32'd0);

        // Grant order with all three requests held, from a fresh reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req_id = {8'd22, 8'd21, 8'd20};
        bus.req = 3'b111;
        ng = 0;
        pg = '0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (bus.gnt != '0 && pg == '0) begin
                for (int b = 0; b < N; b++) if (bus.gnt[b]) order[ng] = b;
                ng++;
            end
            pg = bus.gnt;
        end
`ifdef CHART_ARB_RR_EN
        exp_ord = '{0, 1, 2, 0};
`else
        exp_ord = '{0, 0, 0, 0};
`endif
        check("ord_count", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("ord%0d", i), 32'(order[i]), 32'(exp_ord[i]));
        bus.req = 3'b000;
        wait_idle("ord");

        // Bubble: req[1] held one cycle past its rsp_valid.
        bus.req_id[15:8] = 8'd12;
        bus.req = 3'b010;
        wait_rv(1, "bub");
        @(negedge clk);
        check("bub_gap_busy", 32'(bus.busy), 32'd0);
        check("bub_gap_gnt", 32'(bus.gnt), 32'd0);
        @(negedge clk);
        check("bub_regrant", 32'(bus.gnt), 32'b010);
        bus.req = 3'b000;
        wait_idle("bub");
        @(negedge clk);

        // Withdrawal: req[2] dropped right after grant still completes once.
        bus.req_id[23:16] = 8'd9;
        bus.req = 3'b100;
        @(negedge clk);
        check("wd_gnt", 32'(bus.gnt), 32'b100);
        bus.req = 3'b000;
        @(negedge clk);
        @(negedge clk);
        check("wd_rv", 32'(bus.rsp_valid), 32'b100);
        check("wd_chart", 32'(bus.rsp_chart), 32'(mem[9]));
        repeat (3) @(negedge clk);
        check("wd_no_second", 32'(bus.busy), 32'd0);

        // Id change after grant does not affect the transaction in flight.
        bus.req_id[7:0] = 8'd5;
        bus.req = 3'b001;
        @(negedge clk);
        bus.req_id[7:0] = 8'd6;
        wait_rv(0, "idc");
        check("idc_chart", 32'(bus.rsp_chart[15:8]), 32'd5);
        bus.req = 3'b000;
        wait_idle("idc");

        // Reset during WAIT aborts; the still-held req[1] is granted right after.
        bus.req_id[15:8] = 8'd7;
        bus.req = 3'b010;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rw_gnt", 32'(bus.gnt), 32'd0);
        check("rw_rv", 32'(bus.rsp_valid), 32'd0);
        check("rw_rom_id", 32'(bus.rom_chart_id), 32'd0);
        check("rw_chart", 32'(bus.rsp_chart), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rw_regrant", 32'(bus.gnt), 32'b010);
        check("rw_rom_id2", 32'(bus.rom_chart_id), 32'd7);
        wait_rv(1, "rw");
        bus.req = 3'b000;
        wait_idle("rw");

        // Random traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) begin
                    if (bus.rsp_valid[i]) begin
                        if ($urandom_range(0, 3) != 0) bus.req[i] = 1'b0;
                    end else if ($urandom_range(0, 59) == 0) begin
                        bus.req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.req_id[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                end
                if ($urandom_range(0, 9) == 0) bus.req_id[8*i +: 8] = 8'($urandom);
            end
        end
        rst = 1'b0;
        bus.req = '0;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
